// File: rtl/fp16_pkg.sv
// Shared binary16 types and constants for the FP16 multiplier and adder.
// Includes operand classes and the special-result codes carried down the pipe.
package fp16_pkg;

  localparam int          FP16_BIAS    = 15;
  localparam int          FP16_EXP_MAX = 31;
  localparam logic [15:0] FP16_QNAN    = 16'h7E00;
  localparam logic [15:0] FP16_INF     = 16'h7C00;

  typedef struct packed {
    logic       sign;
    logic [4:0] exp;
    logic [9:0] mant;
  } fp16_t;

  typedef enum logic [1:0] {FP_ZERO, FP_NORM, FP_INF, FP_NAN} fp_class_e;

  // SP_INVALID and SP_QNAN both produce the canonical NaN; only the invalid flag differs
  typedef enum logic [2:0] {SP_NONE, SP_QNAN, SP_INVALID, SP_INF, SP_ZERO} special_e;

endpackage

// File: rtl/fp16_classify.sv
// Combinational binary16 unpack and classification; subnormals are treated as zero.
module fp16_classify
  import fp16_pkg::*;
(
  input  logic [15:0] in_val,
  output fp16_t       unpacked,
  output fp_class_e   fp_class,
  output logic        is_snan
);

  always_comb begin
    unpacked = fp16_t'(in_val);
    fp_class = FP_NORM;
    if (unpacked.exp == 5'd0)
      fp_class = FP_ZERO;
    else if (unpacked.exp == 5'(FP16_EXP_MAX))
      fp_class = (unpacked.mant == 10'd0) ? FP_INF : FP_NAN;
    is_snan = (fp_class == FP_NAN) && !unpacked.mant[9];
  end

endmodule

// File: rtl/fp16_mul_pipe.sv
// Pipelined binary16 multiplier: operand reg, classify, 11x11 multiply, normalize/round/pack.
// Define FP_MUL_FLAGS_EN to add the {invalid, overflow, underflow, inexact} flags port.
module fp16_mul_pipe
  import fp16_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int BIAS   = FP16_BIAS
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              stall,
  output logic              out_valid,
  output logic [DATA_W-1:0] result
`ifdef FP_MUL_FLAGS_EN
  ,
  output logic [3:0]        flags
`endif
);

  logic              s0_valid_q, s0_valid_d;
  logic [DATA_W-1:0] s0_a_q, s0_a_d, s0_b_q, s0_b_d;

  logic              s1_valid_q, s1_valid_d;
  logic              s1_sign_q, s1_sign_d;
  logic signed [6:0] s1_esum_q, s1_esum_d;
  logic [9:0]        s1_ma_q, s1_ma_d, s1_mb_q, s1_mb_d;
  special_e          s1_special_q, s1_special_d;

  logic              s2_valid_q, s2_valid_d;
  logic              s2_sign_q, s2_sign_d;
  logic signed [6:0] s2_esum_q, s2_esum_d;
  logic [21:0]       s2_prod_q, s2_prod_d;
  special_e          s2_special_q, s2_special_d;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] result_q, result_d;
`ifdef FP_MUL_FLAGS_EN
  logic [3:0]        flags_q, flags_d;
`endif

  fp16_t     ua, ub;
  fp_class_e ca, cb;
  logic      snan_a, snan_b;

  fp16_classify u_class_a (.in_val(s0_a_q), .unpacked(ua), .fp_class(ca), .is_snan(snan_a));
  fp16_classify u_class_b (.in_val(s0_b_q), .unpacked(ub), .fp_class(cb), .is_snan(snan_b));

  assign in_ready  = !stall;
  assign out_valid = out_valid_q;
  assign result    = result_q;
`ifdef FP_MUL_FLAGS_EN
  assign flags     = flags_q;
`endif

  always_comb begin
    s0_valid_d = s0_valid_q;
    s0_a_d     = s0_a_q;
    s0_b_d     = s0_b_q;
    if (!stall) begin
      s0_valid_d = in_valid;
      s0_a_d     = in_a;
      s0_b_d     = in_b;
    end
  end

  // Special-case priority is resolved once here so later stages only carry a code
  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_sign_d    = s1_sign_q;
    s1_esum_d    = s1_esum_q;
    s1_ma_d      = s1_ma_q;
    s1_mb_d      = s1_mb_q;
    s1_special_d = s1_special_q;
    if (!stall) begin
      s1_valid_d = s0_valid_q;
      s1_sign_d  = ua.sign ^ ub.sign;
      s1_esum_d  = 7'({2'b00, ua.exp}) + 7'({2'b00, ub.exp}) - 7'(BIAS);
      s1_ma_d    = ua.mant;
      s1_mb_d    = ub.mant;
      if (ca == FP_NAN || cb == FP_NAN)
        s1_special_d = (snan_a || snan_b) ? SP_INVALID : SP_QNAN;
      else if ((ca == FP_INF && cb == FP_ZERO) || (ca == FP_ZERO && cb == FP_INF))
        s1_special_d = SP_INVALID;
      else if (ca == FP_INF || cb == FP_INF)
        s1_special_d = SP_INF;
      else if (ca == FP_ZERO || cb == FP_ZERO)
        s1_special_d = SP_ZERO;
      else
        s1_special_d = SP_NONE;
    end
  end

  always_comb begin
    s2_valid_d   = s2_valid_q;
    s2_sign_d    = s2_sign_q;
    s2_esum_d    = s2_esum_q;
    s2_prod_d    = s2_prod_q;
    s2_special_d = s2_special_q;
    if (!stall) begin
      s2_valid_d   = s1_valid_q;
      s2_sign_d    = s1_sign_q;
      s2_esum_d    = s1_esum_q;
      s2_prod_d    = 22'({1'b1, s1_ma_q}) * 22'({1'b1, s1_mb_q});
      s2_special_d = s1_special_q;
    end
  end

  logic              hi, guard, sticky, round_up, ovf, unf;
  logic [9:0]        mant;
  logic [10:0]       mant_rnd;
  logic signed [8:0] exp_fin;
  logic [15:0]       packed_res;

  // A product in [2,4) is folded into the [1,2) window by selecting one bit higher
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    hi       = s2_prod_q[21];
    mant     = hi ? s2_prod_q[20:11] : s2_prod_q[19:10];
    guard    = hi ? s2_prod_q[10] : s2_prod_q[9];
    sticky   = hi ? |s2_prod_q[9:0] : |s2_prod_q[8:0];
    round_up = guard & (sticky | mant[0]);
    mant_rnd = {1'b0, mant} + {10'd0, round_up};
    exp_fin  = {{2{s2_esum_q[6]}}, s2_esum_q} + {8'd0, hi} + {8'd0, mant_rnd[10]};
    ovf      = (exp_fin >= 9'sd31);
    unf      = (exp_fin <= 9'sd0);
    if (ovf)
      packed_res = {s2_sign_q, FP16_INF[14:0]};
    else if (unf)
      packed_res = {s2_sign_q, 15'd0};
    else
      packed_res = {s2_sign_q, exp_fin[4:0], mant_rnd[9:0]};
    case (s2_special_q)
      SP_QNAN, SP_INVALID: packed_res = FP16_QNAN;
      SP_INF:              packed_res = {s2_sign_q, FP16_INF[14:0]};
      SP_ZERO:             packed_res = {s2_sign_q, 15'd0};
      default:             ;
    endcase
    if (!stall) begin
      out_valid_d = s2_valid_q;
      if (s2_valid_q)
        result_d = packed_res;
    end
`ifdef FP_MUL_FLAGS_EN
    flags_d = flags_q;
    if (!stall && s2_valid_q) begin
      case (s2_special_q)
        SP_NONE:    flags_d = {1'b0, ovf, unf, (guard | sticky) & !ovf};
        SP_INVALID: flags_d = 4'b1000;
        default:    flags_d = 4'b0000;
      endcase
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s0_valid_q   <= 1'b0;
      s0_a_q       <= '0;
      s0_b_q       <= '0;
      s1_valid_q   <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_esum_q    <= '0;
      s1_ma_q      <= '0;
      s1_mb_q      <= '0;
      s1_special_q <= SP_NONE;
      s2_valid_q   <= 1'b0;
      s2_sign_q    <= 1'b0;
      s2_esum_q    <= '0;
      s2_prod_q    <= '0;
      s2_special_q <= SP_NONE;
      out_valid_q  <= 1'b0;
      result_q     <= '0;
`ifdef FP_MUL_FLAGS_EN
      flags_q      <= '0;
`endif
    end else begin
      s0_valid_q   <= s0_valid_d;
      s0_a_q       <= s0_a_d;
      s0_b_q       <= s0_b_d;
      s1_valid_q   <= s1_valid_d;
      s1_sign_q    <= s1_sign_d;
      s1_esum_q    <= s1_esum_d;
      s1_ma_q      <= s1_ma_d;
      s1_mb_q      <= s1_mb_d;
      s1_special_q <= s1_special_d;
      s2_valid_q   <= s2_valid_d;
      s2_sign_q    <= s2_sign_d;
      s2_esum_q    <= s2_esum_d;
      s2_prod_q    <= s2_prod_d;
      s2_special_q <= s2_special_d;
      out_valid_q  <= out_valid_d;
      result_q     <= result_d;
`ifdef FP_MUL_FLAGS_EN
      flags_q      <= flags_d;
`endif
    end
  end

endmodule

// File: tb/tb_fp16_mul_pipe.sv
// Self-checking bench for fp16_mul_pipe: value-level FP16 reference plus directed and random traffic.
// Flag checks are active only when FP_MUL_FLAGS_EN is defined.
module tb_fp16_mul_pipe;

  logic        clk = 1'b0;
  logic        rst, in_valid, stall, in_ready, out_valid;
  logic [15:0] in_a, in_b, result;
`ifdef FP_MUL_FLAGS_EN
  logic [3:0]  flags;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  fp16_mul_pipe dut (
    .CLK(clk), .RST(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .stall(stall), .out_valid(out_valid), .result(result)
`ifdef FP_MUL_FLAGS_EN
    , .flags(flags)
`endif
  );

  always #5 clk = ~clk;

  // Reference product as {invalid, overflow, underflow, inexact, result}, from real-valued rules
  function automatic logic [19:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    int  ea, eb, ma, mb, p, k, e, sh, q, rem, half;
    bit  s, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
    s  = a[15] ^ b[15];
    ea = int'(a[14:10]); eb = int'(b[14:10]);
    ma = int'(a[9:0]);   mb = int'(b[9:0]);
    a_zero = (ea == 0);  b_zero = (eb == 0);
    a_inf  = (ea == 31) && (ma == 0);  b_inf = (eb == 31) && (mb == 0);
    a_nan  = (ea == 31) && (ma != 0);  b_nan = (eb == 31) && (mb != 0);
    a_snan = a_nan && (ma < 512);      b_snan = b_nan && (mb < 512);
    if (a_nan || b_nan) return {a_snan || b_snan, 3'b000, 16'h7E00};
    if ((a_inf && b_zero) || (a_zero && b_inf)) return {4'b1000, 16'h7E00};
    if (a_inf || b_inf) return {4'b0000, s, 15'h7C00};
    if (a_zero || b_zero) return {4'b0000, s, 15'h0000};
    p    = (1024 + ma) * (1024 + mb);
    k    = (p >= (1 << 21)) ? 21 : 20;
    e    = ea + eb - 35 + k;
    sh   = k - 10;
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 1 << (sh - 1);
    if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
    if (q == 2048) begin q = 1024; e = e + 1; end
    if (e >= 31) return {4'b0100, s, 15'h7C00};
    if (e <= 0) return {3'b001, rem != 0, s, 15'h0000};
    return {3'b000, rem != 0, s, 5'(e), 10'(q - 1024)};
  endfunction

  function automatic logic [15:0] rand_op();
    logic [15:0] specials [8] = '{16'h0000, 16'h8000, 16'h7C00, 16'hFC00,
                                  16'h7E00, 16'h7C01, 16'h0001, 16'h7BFF};
    int sel = $urandom_range(3);
    if (sel == 0) return specials[$urandom_range(7)];
    if (sel == 1) return {1'($urandom), 5'($urandom_range(20, 10)), 10'($urandom)};
    return 16'($urandom);
  endfunction

  task automatic check_output(input string name, input logic [19:0] act, input logic [19:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected-output delay line: an accepted beat emerges three non-stalled edges after acceptance
  bit          m_v [4] = '{default: 1'b0};
  logic [19:0] m_d [4] = '{default: 20'h0};
  bit          advanced = 1'b0;
  logic [15:0] got [$];

  always @(posedge clk) begin
    advanced = !rst && !stall;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin m_v[i] = 1'b0; m_d[i] = 20'h0; end
    end else if (!stall) begin
      for (int i = 3; i > 0; i--) begin m_v[i] = m_v[i-1]; m_d[i] = m_d[i-1]; end
      m_v[0] = in_valid;
      m_d[0] = ref_mul(in_a, in_b);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check_output("in_ready", {19'd0, in_ready}, {19'd0, !stall});
      check_output("out_valid", {19'd0, out_valid}, {19'd0, m_v[3]});
      if (m_v[3]) begin
        check_output("result", {4'd0, result}, {4'd0, m_d[3][15:0]});
`ifdef FP_MUL_FLAGS_EN
        check_output("flags", {16'd0, flags}, {16'd0, m_d[3][19:16]});
`endif
      end
      if (advanced && out_valid) got.push_back(result);
    end
  end

  task automatic apply_stimulus(input logic [15:0] a, input logic [15:0] b);
    in_valid = 1'b1; in_a = a; in_b = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic single_beat(input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] exp_res, input logic [3:0] exp_flags);
    apply_stimulus(a, b);
    tick();
    tick();
    check_output("latency_early", {19'd0, out_valid}, 20'd0);
    tick();
    check_output("latency_valid", {19'd0, out_valid}, 20'd1);
    check_output("directed_result", {4'd0, result}, {4'd0, exp_res});
`ifdef FP_MUL_FLAGS_EN
    check_output("directed_flags", {16'd0, flags}, {16'd0, exp_flags});
`else
    if (exp_flags != ref_mul(a, b)[19:16])
      check_output("model_flags", {16'd0, ref_mul(a, b)[19:16]}, {16'd0, exp_flags});
`endif
    tick();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; stall = 1'b0; in_a = '0; in_b = '0;
    repeat (3) tick();
    rst = 1'b0;
    check_output("reset_out_valid", {19'd0, out_valid}, 20'd0);
    check_output("reset_result", {4'd0, result}, 20'h0);
`ifdef FP_MUL_FLAGS_EN
    check_output("reset_flags", {16'd0, flags}, 20'h0);
`endif
    chk_en = 1'b1;

    check_output("model_1x2", ref_mul(16'h3C00, 16'h4000), 20'h0_4000);
    check_output("model_1p5sq", ref_mul(16'h3E00, 16'h3E00), 20'h0_4080);
    check_output("model_inexact", ref_mul(16'h3C01, 16'h3C01), 20'h1_3C02);
    check_output("model_ovf", ref_mul(16'h7BFF, 16'h7BFF), 20'h4_7C00);
    check_output("model_unf", ref_mul(16'h0400, 16'h0400), 20'h2_0000);
    check_output("model_inf0", ref_mul(16'h7C00, 16'h0000), 20'h8_7E00);
    check_output("model_snan", ref_mul(16'h7C01, 16'h3C00), 20'h8_7E00);

    single_beat(16'h3C00, 16'h4000, 16'h4000, 4'b0000);
    single_beat(16'h3E00, 16'h3E00, 16'h4080, 4'b0000);
    single_beat(16'h3C01, 16'h3C01, 16'h3C02, 4'b0001);
    single_beat(16'h7BFF, 16'h7BFF, 16'h7C00, 4'b0100);
    single_beat(16'h0400, 16'h0400, 16'h0000, 4'b0010);
    single_beat(16'h8400, 16'h0400, 16'h8000, 4'b0010);
    single_beat(16'h7C00, 16'h0000, 16'h7E00, 4'b1000);
    single_beat(16'h7C01, 16'h3C00, 16'h7E00, 4'b1000);
    single_beat(16'hFC00, 16'h4000, 16'hFC00, 4'b0000);
    single_beat(16'h7E00, 16'h3C00, 16'h7E00, 4'b0000);

    // Back-to-back with a two-cycle stall after the second accept; third beat waits
    tick();
    got.delete();
    in_valid = 1'b1; in_a = 16'h3C00; in_b = 16'h3C00; tick();
    in_a = 16'h4000; in_b = 16'h4000; tick();
    stall = 1'b1; in_a = 16'h4200; in_b = 16'h4000;
    tick(); tick();
    stall = 1'b0; tick();
    in_valid = 1'b0;
    repeat (6) tick();
    check_output("stall_count", 20'(got.size()), 20'd3);
    if (got.size() == 3) begin
      check_output("stall_out0", {4'd0, got[0]}, 20'h3C00);
      check_output("stall_out1", {4'd0, got[1]}, 20'h4400);
      check_output("stall_out2", {4'd0, got[2]}, 20'h4600);
    end

    // Reset with three beats in flight while stalled
    in_valid = 1'b1; in_a = 16'h3C00; in_b = 16'h4000; tick();
    in_a = 16'h4000; in_b = 16'h4000; tick();
    in_a = 16'h4200; in_b = 16'h4000; tick();
    in_valid = 1'b0; stall = 1'b1; rst = 1'b1; tick();
    check_output("rst_flight_valid", {19'd0, out_valid}, 20'd0);
    check_output("rst_flight_result", {4'd0, result}, 20'h0);
    rst = 1'b0; stall = 1'b0;
    got.delete();
    repeat (6) tick();
    check_output("rst_no_stale", 20'(got.size()), 20'd0);
    single_beat(16'h4000, 16'h4200, 16'h4600, 4'b0000);

    for (int c = 0; c < 3000; c++) begin
      in_valid = ($urandom_range(3) != 0);
      stall    = ($urandom_range(4) == 0);
      rst      = ($urandom_range(599) == 0);
      in_a     = rand_op();
      in_b     = rand_op();
      tick();
    end
    rst = 1'b0; stall = 1'b0; in_valid = 1'b0;
    repeat (8) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
